// File: rtl/assoc_mem_scan.sv
// Associative-memory search: accumulates Hamming distances between a query HV and
// streamed class HVs, then scans the scores for the nearest class and a confidence margin.
//
// state | meaning
// IDLE  | waiting for am_start_i, config latched on start
// ACCUM | accepting class HVs, one score update per handshake
// SCAN  | one score examined per cycle, best/second-best tracked
// OUT   | prediction valid, held until predict_ready_i
module assoc_mem_scan #(
    parameter int HVDimension = 512,
    parameter int NumClasses  = 32,
    parameter int ScoreWidth  = 16,
    parameter int PassWidth   = 5,
    localparam int IdxWidth   = $clog2(NumClasses)
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [HVDimension-1:0] query_hv_i,
    input  logic                   am_start_i,
    input  logic                   abort_i,
    output logic                   am_busy_o,
    output logic                   am_stall_o,
    input  logic [HVDimension-1:0] class_hv_i,
    input  logic                   class_hv_valid_i,
    output logic                   class_hv_ready_o,
    input  logic [IdxWidth:0]      num_class_i,
    input  logic [PassWidth-1:0]   num_pass_i,
    input  logic [ScoreWidth-1:0]  margin_thresh_i,
    output logic [IdxWidth-1:0]    predict_o,
    output logic [ScoreWidth-1:0]  predict_score_o,
    output logic [ScoreWidth-1:0]  predict_margin_o,
    output logic                   predict_reject_o,
    output logic                   predict_valid_o,
    input  logic                   predict_ready_i
);

    typedef enum logic [1:0] {ST_IDLE, ST_ACCUM, ST_SCAN, ST_OUT} state_e;

    localparam logic [IdxWidth:0] NcMax = (IdxWidth+1)'(NumClasses);
    localparam logic [IdxWidth:0] NcOne = (IdxWidth+1)'(1);

    state_e                state_q;
    logic [ScoreWidth-1:0] score_q [NumClasses];
    logic [IdxWidth-1:0]   class_cnt_q, last_class_q, scan_idx_q, best_idx_q;
    logic [PassWidth-1:0]  pass_cnt_q, last_pass_q;
    logic [ScoreWidth-1:0] thresh_q, best_q, second_q;

    logic [HVDimension-1:0] diff;
    logic [ScoreWidth-1:0]  pop;
    logic [ScoreWidth:0]    acc_sum;
    logic [ScoreWidth-1:0]  acc_sat;
    logic [IdxWidth:0]      nc_clamp;
    logic [IdxWidth-1:0]    start_last_class;
    logic [PassWidth-1:0]   start_last_pass;
    logic [ScoreWidth-1:0]  scan_score, best_nxt, second_nxt, margin_nxt;
    logic [IdxWidth-1:0]    best_idx_nxt;
    logic                   hs;

    assign am_busy_o        = (state_q != ST_IDLE);
    assign am_stall_o       = am_busy_o && am_start_i;
    assign class_hv_ready_o = (state_q == ST_ACCUM);
    assign predict_valid_o  = (state_q == ST_OUT);
    assign hs               = (state_q == ST_ACCUM) && class_hv_valid_i;

    always_comb begin
        diff = query_hv_i ^ class_hv_i;
        pop  = '0;
        for (int i = 0; i < HVDimension; i++) begin
            pop = pop + ScoreWidth'(diff[i]);
        end
        acc_sum = {1'b0, score_q[class_cnt_q]} + {1'b0, pop};
        acc_sat = acc_sum[ScoreWidth] ? '1 : acc_sum[ScoreWidth-1:0];
    end

    always_comb begin
        if (num_class_i == '0)        nc_clamp = NcOne;
        else if (num_class_i > NcMax) nc_clamp = NcMax;
        else                          nc_clamp = num_class_i;
        start_last_class = IdxWidth'(nc_clamp - NcOne);
        start_last_pass  = (num_pass_i == '0) ? '0 : num_pass_i - PassWidth'(1);
    end

    // Strict less-than keeps the lowest index on ties; an equal score still lands in second.
    always_comb begin
        scan_score   = score_q[scan_idx_q];
        best_nxt     = best_q;
        second_nxt   = second_q;
        best_idx_nxt = best_idx_q;
        if (scan_idx_q == '0) begin
            best_nxt     = scan_score;
            second_nxt   = '1;
            best_idx_nxt = '0;
        end else if (scan_score < best_q) begin
            best_nxt     = scan_score;
            second_nxt   = best_q;
            best_idx_nxt = scan_idx_q;
        end else if (scan_score < second_q) begin
            second_nxt   = scan_score;
        end
        margin_nxt = (last_class_q == '0) ? '1 : second_nxt - best_nxt;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q          <= ST_IDLE;
            for (int c = 0; c < NumClasses; c++) score_q[c] <= '0;
            class_cnt_q      <= '0;
            pass_cnt_q       <= '0;
            last_class_q     <= '0;
            last_pass_q      <= '0;
            scan_idx_q       <= '0;
            thresh_q         <= '0;
            best_q           <= '0;
            second_q         <= '0;
            best_idx_q       <= '0;
            predict_o        <= '0;
            predict_score_o  <= '0;
            predict_margin_o <= '0;
            predict_reject_o <= 1'b0;
        end else if (abort_i) begin
            state_q <= ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (am_start_i) begin
                        state_q      <= ST_ACCUM;
                        for (int c = 0; c < NumClasses; c++) score_q[c] <= '0;
                        class_cnt_q  <= '0;
                        pass_cnt_q   <= '0;
                        last_class_q <= start_last_class;
                        last_pass_q  <= start_last_pass;
                        thresh_q     <= margin_thresh_i;
                    end
                end
                ST_ACCUM: begin
                    if (hs) begin
                        score_q[class_cnt_q] <= acc_sat;
                        if (class_cnt_q == last_class_q) begin
                            class_cnt_q <= '0;
                            if (pass_cnt_q == last_pass_q) begin
                                state_q    <= ST_SCAN;
                                scan_idx_q <= '0;
                            end else begin
                                pass_cnt_q <= pass_cnt_q + PassWidth'(1);
                            end
                        end else begin
                            class_cnt_q <= class_cnt_q + IdxWidth'(1);
                        end
                    end
                end
                ST_SCAN: begin
                    best_q     <= best_nxt;
                    second_q   <= second_nxt;
                    best_idx_q <= best_idx_nxt;
                    if (scan_idx_q == last_class_q) begin
                        state_q          <= ST_OUT;
                        predict_o        <= best_idx_nxt;
                        predict_score_o  <= best_nxt;
                        predict_margin_o <= margin_nxt;
                        predict_reject_o <= (margin_nxt < thresh_q);
                    end else begin
                        scan_idx_q <= scan_idx_q + IdxWidth'(1);
                    end
                end
                ST_OUT: begin
                    if (predict_ready_i) state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule
